// File: rtl/tdm_demux_1to4_pkg.sv
// Shared definitions for the 1-to-4 TDM demultiplexer: FSM state encoding
// and slot-counter geometry.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ALIGNED = 2'd2
    } tdm_state_e;

endpackage : tdm_pkg

// File: rtl/tdm_demux_1to4_if.sv
// Bus bundle for the TDM demultiplexer: serial sample input on one side,
// parallel reassembled frame plus status on the other.
interface tdm_demux_1to4_if #(
    parameter int WIDTH = 8
);
    import tdm_pkg::*;

    logic                  in_valid;
    logic                  in_sof;
    logic [WIDTH-1:0]      in_data;
    logic [WIDTH-1:0]      out_a;
    logic [WIDTH-1:0]      out_b;
    logic [WIDTH-1:0]      out_c;
    logic [WIDTH-1:0]      out_d;
    logic                  out_valid;
    logic [SLOT_W-1:0]     slot;
    logic                  synced;
    logic                  frame_err;

    // Producer of the serial stream and consumer of the parallel frame.
    modport master (
        output in_valid, in_sof, in_data,
        input  out_a, out_b, out_c, out_d, out_valid, slot, synced, frame_err
    );

    // The demultiplexer itself.
    modport slave (
        input  in_valid, in_sof, in_data,
        output out_a, out_b, out_c, out_d, out_valid, slot, synced, frame_err
    );

endinterface : tdm_demux_1to4_if

// File: rtl/tdm_demux_1to4.sv
// 1-to-4 TDM demultiplexer. Collects slots a..c into staging registers and
// transfers the whole frame to the output bank on the edge that accepts
// slot d, so outputs only ever change to a complete, aligned frame.
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    tdm_demux_1to4_if.slave   bus
);

    tdm_state_e           state_r;
    logic [SLOT_W-1:0]    slot_r;
    logic [WIDTH-1:0]     s0_r;
    logic [WIDTH-1:0]     s1_r;
    logic [WIDTH-1:0]     s2_r;
    logic [WIDTH-1:0]     out_a_r;
    logic [WIDTH-1:0]     out_b_r;
    logic [WIDTH-1:0]     out_c_r;
    logic [WIDTH-1:0]     out_d_r;
    logic                 out_valid_r;
    logic                 synced_r;
    logic                 frame_err_r;

    // Frame alignment FSM, slot counter, staging and output bank in one register process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_HUNT;
            slot_r      <= {SLOT_W{1'b0}};
            s0_r        <= {WIDTH{1'b0}};
            s1_r        <= {WIDTH{1'b0}};
            s2_r        <= {WIDTH{1'b0}};
            out_a_r     <= {WIDTH{1'b0}};
            out_b_r     <= {WIDTH{1'b0}};
            out_c_r     <= {WIDTH{1'b0}};
            out_d_r     <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            synced_r    <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            // Strobes are single-cycle; they are re-asserted below only when an event occurs.
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            if (bus.in_valid) begin
                case (state_r)
                    ST_HUNT: begin
                        if (bus.in_sof) begin
                            s0_r     <= bus.in_data;
                            slot_r   <= 2'd1;
                            state_r  <= ST_COLLECT;
                            synced_r <= 1'b1;
                        end else begin
                            // Unaligned samples are silently discarded while hunting.
                            slot_r   <= 2'd0;
                        end
                    end
                    ST_COLLECT: begin
                        if (bus.in_sof) begin
                            // Early SOF: drop the partial frame and restart from this sample.
                            frame_err_r <= 1'b1;
                            s0_r        <= bus.in_data;
                            slot_r      <= 2'd1;
                        end else begin
                            case (slot_r)
                                2'd1: begin
                                    s1_r   <= bus.in_data;
                                    slot_r <= 2'd2;
                                end
                                2'd2: begin
                                    s2_r   <= bus.in_data;
                                    slot_r <= 2'd3;
                                end
                                2'd3: begin
                                    out_a_r     <= s0_r;
                                    out_b_r     <= s1_r;
                                    out_c_r     <= s2_r;
                                    out_d_r     <= bus.in_data;
                                    out_valid_r <= 1'b1;
                                    slot_r      <= 2'd0;
                                    state_r     <= ST_ALIGNED;
                                end
                                default: begin
                                    // Slot 0 cannot occur while collecting; recover by re-hunting.
                                    slot_r   <= 2'd0;
                                    state_r  <= ST_HUNT;
                                    synced_r <= 1'b0;
                                end
                            endcase
                        end
                    end
                    ST_ALIGNED: begin
                        if (bus.in_sof) begin
                            s0_r    <= bus.in_data;
                            slot_r  <= 2'd1;
                            state_r <= ST_COLLECT;
                        end else begin
                            // Missing SOF where one was due: alignment is lost.
                            frame_err_r <= 1'b1;
                            slot_r      <= 2'd0;
                            state_r     <= ST_HUNT;
                            synced_r    <= 1'b0;
                        end
                    end
                    default: begin
                        state_r  <= ST_HUNT;
                        slot_r   <= 2'd0;
                        synced_r <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bus.out_a     = out_a_r;
    assign bus.out_b     = out_b_r;
    assign bus.out_c     = out_c_r;
    assign bus.out_d     = out_d_r;
    assign bus.out_valid = out_valid_r;
    assign bus.slot      = slot_r;
    assign bus.synced    = synced_r;
    assign bus.frame_err = frame_err_r;

endmodule : tdm_demux_1to4

// File: tb/tb_tdm_demux_1to4.sv
// Self-checking bench for tdm_demux_1to4: expected frames are queued when
// slot d is driven and compared when out_valid appears.
module tb_tdm_demux_1to4;
    import tdm_pkg::*;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   valid_cnt;
    int   err_cnt;
    logic [4*WIDTH-1:0] sb[$];

    tdm_demux_1to4_if #(.WIDTH(WIDTH)) bus ();

    tdm_demux_1to4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // One clock of stimulus; samples outputs 1 time unit after the edge and scores any frame.
    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
        logic [4*WIDTH-1:0] exp_f;
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = 8'h00;
        if (bus.frame_err === 1'b1) err_cnt++;
        if (bus.out_valid === 1'b1) begin
            valid_cnt++;
            checks++;
            if (bus.frame_err !== 1'b0) begin
                failures++;
                $display("FAIL strobe_overlap: frame_err=%b with out_valid, required 0", bus.frame_err);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_frame: got %h_%h_%h_%h, required no out_valid",
                         bus.out_a, bus.out_b, bus.out_c, bus.out_d);
            end else begin
                exp_f = sb.pop_front();
                if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== exp_f) begin
                    failures++;
                    $display("FAIL frame_data: got %h_%h_%h_%h, required %h",
                             bus.out_a, bus.out_b, bus.out_c, bus.out_d, exp_f);
                end
            end
        end
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                              input int gaps);
        drive(1'b1, 1'b1, a);
        for (int i = 0; i < gaps; i++) drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, b);
        for (int i = 0; i < gaps; i++) drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, c);
        for (int i = 0; i < gaps; i++) drive(1'b0, 1'b0, 8'h00);
        sb.push_back({a, b, c, d});
        drive(1'b1, 1'b0, d);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_valid, bus.slot,
             bus.synced, bus.frame_err} !== {(4*WIDTH+5){1'b0}}) begin
            failures++;
            $display("FAIL %s: outs=%h_%h_%h_%h v=%b slot=%0d sync=%b err=%b, required all 0",
                     tag, bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_valid,
                     bus.slot, bus.synced, bus.frame_err);
        end
    endtask

    task automatic test_reset();
        int v0;
        #3 rst_n = 1'b0;
        #1 check_zero("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v0 = valid_cnt;
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (valid_cnt != v0 || bus.synced !== 1'b0) begin
            failures++;
            $display("FAIL idle: pulses=%0d synced=%b, required 0 and 0", valid_cnt - v0, bus.synced);
        end
    endtask

    task automatic test_clean_frame();
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_a !== 8'h11 || bus.out_d !== 8'h44 || bus.slot !== 2'd0) begin
            failures++;
            $display("FAIL clean_latency: v=%b a=%h d=%h slot=%0d, required 1 11 44 0",
                     bus.out_valid, bus.out_a, bus.out_d, bus.slot);
        end
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.synced !== 1'b1) begin
            failures++;
            $display("FAIL clean_pulse: v=%b synced=%b, required 0 1", bus.out_valid, bus.synced);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_cnt;
        send_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4, 2);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'hB1);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'hB2);
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.slot !== 2'd2 || {bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== 32'hA1A2A3A4) begin
            failures++;
            $display("FAIL gap_hold: slot=%0d outs=%h_%h_%h_%h, required 2 a1_a2_a3_a4",
                     bus.slot, bus.out_a, bus.out_b, bus.out_c, bus.out_d);
        end
        drive(1'b1, 1'b0, 8'hB3);
        sb.push_back(32'hB1B2B3B4);
        drive(1'b1, 1'b0, 8'hB4);
        send_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4, 0);
        checks++;
        if (valid_cnt - v0 != 3) begin
            failures++;
            $display("FAIL b2b_count: pulses=%0d, required 3", valid_cnt - v0);
        end
    endtask

    task automatic test_presync();
        int e0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        e0 = err_cnt;
        drive(1'b1, 1'b0, 8'hAA);
        drive(1'b1, 1'b0, 8'hBB);
        checks++;
        if (bus.synced !== 1'b0 || err_cnt != e0) begin
            failures++;
            $display("FAIL presync: synced=%b errs=%0d, required 0 0", bus.synced, err_cnt - e0);
        end
        drive(1'b1, 1'b1, 8'h5A);
        checks++;
        if (bus.synced !== 1'b1) begin
            failures++;
            $display("FAIL presync_lock: synced=%b, required 1", bus.synced);
        end
        drive(1'b1, 1'b0, 8'h6B);
        drive(1'b1, 1'b0, 8'h7C);
        sb.push_back(32'h5A6B7C8D);
        drive(1'b1, 1'b0, 8'h8D);
    endtask

    task automatic test_early_sof();
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b0, 8'h02);
        drive(1'b1, 1'b1, 8'h10);
        checks++;
        if (bus.frame_err !== 1'b1 || bus.slot !== 2'd1 || bus.out_a !== 8'h5A) begin
            failures++;
            $display("FAIL early_sof: err=%b slot=%0d a=%h, required 1 1 5a",
                     bus.frame_err, bus.slot, bus.out_a);
        end
        drive(1'b1, 1'b0, 8'h20);
        checks++;
        if (bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL early_sof_pulse: err=%b, required 0", bus.frame_err);
        end
        drive(1'b1, 1'b0, 8'h30);
        sb.push_back(32'h10203040);
        drive(1'b1, 1'b0, 8'h40);
    endtask

    task automatic test_missing_sof();
        drive(1'b1, 1'b0, 8'h55);
        checks++;
        if (bus.frame_err !== 1'b1 || bus.synced !== 1'b0 || bus.slot !== 2'd0 || bus.out_d !== 8'h40) begin
            failures++;
            $display("FAIL missing_sof: err=%b synced=%b slot=%0d d=%h, required 1 0 0 40",
                     bus.frame_err, bus.synced, bus.slot, bus.out_d);
        end
    endtask

    task automatic test_midframe_reset();
        int e0;
        send_frame(8'hE1, 8'hE2, 8'hE3, 8'hE4, 0);
        drive(1'b1, 1'b1, 8'hF1);
        drive(1'b1, 1'b0, 8'hF2);
        #2 rst_n = 1'b0;
        #1 check_zero("midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        e0 = err_cnt;
        drive(1'b1, 1'b0, 8'hF3);
        checks++;
        if (bus.synced !== 1'b0 || err_cnt != e0 || bus.out_a !== 8'h00) begin
            failures++;
            $display("FAIL reset_hunt: synced=%b errs=%0d a=%h, required 0 0 00",
                     bus.synced, err_cnt - e0, bus.out_a);
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b1;
        checks       = 0;
        failures     = 0;
        valid_cnt    = 0;
        err_cnt      = 0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_presync();
        test_early_sof();
        test_missing_sof();
        test_midframe_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d frames never delivered, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tdm_demux_1to4
